uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1250, clk cycles per serial bit; legal range 4..65535.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rx  input  1  asynchronous serial line; idle high.
REQ-005 rx_data  output  8  last correctly received byte.
REQ-006 rx_valid  output  1  one-cycle pulse; rx_data updated in the same cycle.
REQ-007 frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-008 parity_err  output  1  one-cycle pulse; parity mismatch (see REQ-026).
REQ-009 busy  output  1  high in every state except IDLE.

Function
REQ-010 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, optional parity bit (REQ-026), 1 stop bit (1).
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use; both flops reset to 1.
REQ-012 States SHALL be IDLE, START, DATA, PARITY (present only with the macro), STOP.
REQ-013 IDLE SHALL leave on a falling edge of the synchronized line (previous sample 1, current sample 0) only; a line held low SHALL NOT retrigger.
REQ-014 A 16-bit bit-timer SHALL be cleared on entry to START and SHALL count clk cycles.
REQ-015 START SHALL re-sample the line after CLKS_PER_BIT/2 cycles (integer division): if 0, go to DATA with the timer cleared; if 1, treat it as a glitch and return to IDLE with no output pulse.
REQ-016 DATA SHALL sample one bit every CLKS_PER_BIT cycles, shift it in LSB first, and use a 3-bit counter; after bit 7 go to PARITY or STOP.
REQ-017 STOP SHALL sample the line CLKS_PER_BIT cycles after the last data or parity sample, then return to IDLE on the next cycle.
REQ-018 Stop sample 1 with no parity error: in the cycle after the stop sample, rx_data <= shift register and rx_valid = 1 for exactly one cycle.
REQ-019 Stop sample 0: frame_err SHALL pulse for one cycle, rx_valid SHALL stay 0, and rx_data SHALL keep its previous value.
REQ-020 Parity error and frame error together: both pulses in the same cycle; rx_valid = 0.
REQ-021 A new frame SHALL be accepted from the first IDLE cycle after STOP, so back-to-back frames are received without loss.
REQ-022 Latency SHALL be rx_valid = 1 exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (+CLKS_PER_BIT with parity) + 1 cycles after the rx falling edge, plus or minus 1 cycle.

Reset
REQ-023 While rst = 1: state IDLE, timer and counters 0, shift register 0, rx_data = 8'h00, rx_valid = frame_err = parity_err = busy = 0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no pulse on any output; after release, reception SHALL begin only on a fresh falling edge.

Configuration
REQ-025 Macro UART_RX_PARITY_EN SHALL control parity support.
REQ-026 With UART_RX_PARITY_EN defined: the PARITY state samples an even-parity bit CLKS_PER_BIT cycles after bit 7; a mismatch (XOR of data and parity = 1) pulses parity_err in the cycle after the stop sample and suppresses rx_valid.
REQ-027 Without the macro: no PARITY state, frame is 8N1, parity_err is tied 0.

Verification (CLKS_PER_BIT = 16)
REQ-028 Idle, 8N1 frame 0xA5 -> one rx_valid pulse, rx_data = 8'hA5, frame_err = 0, busy falls after STOP.
REQ-029 Frames 0x00 and 0xFF back-to-back with no idle gap -> two rx_valid pulses, data 00 then FF.
REQ-030 rx low for 6 cycles, then high -> return to IDLE, no pulse on any output, rx_data unchanged.
REQ-031 Frame 0x3C with stop bit 0, line then held low for 40 cycles -> one frame_err pulse, no rx_valid, no retrigger until the line rises and falls again.
REQ-032 rst pulsed during DATA bit 4 of frame 0x81, then frame 0x42 -> no output pulse for the first frame; rx_valid with rx_data = 8'h42.
REQ-033 With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 -> parity_err pulse, no rx_valid; with parity bit 1 -> rx_valid, rx_data = 8'h07.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial receive port bundle.
//   rx         - asynchronous serial line into the receiver (idle high)
//   rx_data    - last correctly received byte
//   rx_valid   - one-cycle pulse, rx_data updated in the same cycle
//   frame_err  - one-cycle pulse, stop bit sampled low
//   parity_err - one-cycle pulse, even-parity mismatch
//   busy       - receiver is not idle
// master: the side driving the line (line source / test driver)
// slave : the receiver itself
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport master (
    output rx,
    input  rx_data, rx_valid, frame_err, parity_err, busy
  );

  modport slave (
    input  rx,
    output rx_data, rx_valid, frame_err, parity_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8 data bits LSB first, 1 stop bit.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN (8E1);
// default build is 8N1 with parity_err tied low.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - uart_rx_if.slave (rx in; rx_data, rx_valid, frame_err,
//          parity_err, busy out)
// Parameter CLKS_PER_BIT: clk cycles per serial bit (4..65535).
//
// state   | meaning
// IDLE    | waiting for a falling edge on the synchronized line
// START   | half-bit wait, confirm start bit still low
// DATA    | sample 8 data bits, one per bit period
// PARITY  | sample even-parity bit (UART_RX_PARITY_EN only)
// STOP    | sample stop bit, issue result pulse on exit
module uart_rx #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t      r_state, w_next;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  logic [1:0]  r_sync_vld;
  logic [15:0] r_timer;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid, r_frame_err;
  logic        w_fall, w_half_done, w_bit_done, w_par_mismatch, w_busy;

`ifdef UART_RX_PARITY_EN
  logic        r_par_bit, r_parity_err;
  assign w_par_mismatch = (^r_shift) ^ r_par_bit;
`else
  assign w_par_mismatch = 1'b0;
`endif

  // The synchronizer flops reset high, so r_sync_vld marks when r_rx_s2
  // holds a real line sample. r_rx_prev only reports high for a real
  // high sample; a line already low at reset release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_sync_vld <= 2'b00;
      r_rx_prev  <= 1'b0;
    end else begin
      r_rx_s1    <= bus.rx;
      r_rx_s2    <= r_rx_s1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      r_rx_prev  <= r_sync_vld[1] & r_rx_s2;
    end
  end

  assign w_fall      = r_rx_prev & ~r_rx_s2;
  assign w_half_done = (r_timer == 16'(HALF_BIT - 1));
  assign w_bit_done  = (r_timer == 16'(CLKS_PER_BIT - 1));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_fall) w_next = S_START;
      S_START: if (w_half_done) w_next = r_rx_s2 ? S_IDLE : S_DATA;
      S_DATA:
        if (w_bit_done && (r_bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          w_next = S_PARITY;
`else
          w_next = S_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (w_bit_done) w_next = S_STOP;
`endif
      S_STOP:  if (w_bit_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // output logic
  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  // Datapath: timer restarts on every state change and on each bit sample.
  // Result pulses are registered at the stop sample, so they appear in the
  // first IDLE cycle, which also accepts the next start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer     <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if ((r_state == S_IDLE) || (w_next != r_state) || w_bit_done)
        r_timer <= '0;
      else
        r_timer <= r_timer + 16'd1;

      if (r_state == S_START) r_bit_cnt <= '0;

      if ((r_state == S_DATA) && w_bit_done) begin
        r_shift   <= {r_rx_s2, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

`ifdef UART_RX_PARITY_EN
      if ((r_state == S_PARITY) && w_bit_done) r_par_bit <= r_rx_s2;
`endif

      if ((r_state == S_STOP) && w_bit_done) begin
        r_frame_err <= ~r_rx_s2;
`ifdef UART_RX_PARITY_EN
        r_parity_err <= w_par_mismatch;
`endif
        if (r_rx_s2 && !w_par_mismatch) begin
          r_rx_valid <= 1'b1;
          r_rx_data  <= r_shift;
        end
      end
    end
  end

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = w_busy;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = r_parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  localparam int C = 16;
  // rx fall to rx_valid: 2 sync + 1 edge + C/2 + 9*C
  localparam int LAT = 3 + C / 2 + 9 * C;

  logic clk = 1'b0;
  logic rst;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // passive monitor, sampled on the falling edge
  int         n_valid = 0, n_ferr = 0, n_perr = 0, n_busy = 0;
  int         t_valid = 0;
  int         t_fall  = 0;
  logic [7:0] got [0:63];

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      got[n_valid % 64] = bus.rx_data;
      t_valid = cyc;
      n_valid++;
    end
    if (bus.frame_err === 1'b1) n_ferr++;
    if (bus.parity_err === 1'b1) n_perr++;
    if (bus.busy === 1'b1) n_busy++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.rx = b;
    wait_cyc(C);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic use_par, input logic par_b);
    t_fall = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (use_par) send_bit(par_b);
    send_bit(stop_b);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    bus.rx = 1'b1;
    wait_cyc(4);
    cmp_cnt++; if (bus.rx_data !== 8'h00) begin err_cnt++; $display("FAIL reset_rx_data got=%h exp=00", bus.rx_data); end
    cmp_cnt++; if (bus.rx_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_rx_valid got=%b exp=0", bus.rx_valid); end
    cmp_cnt++; if (bus.frame_err !== 1'b0) begin err_cnt++; $display("FAIL reset_frame_err got=%b exp=0", bus.frame_err); end
    cmp_cnt++; if (bus.parity_err !== 1'b0) begin err_cnt++; $display("FAIL reset_parity_err got=%b exp=0", bus.parity_err); end
    cmp_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    rst = 1'b0;
    wait_cyc(10);
  endtask

  task automatic test_basic();
    int v0, f0, b0;
    v0 = n_valid; f0 = n_ferr; b0 = n_busy;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    wait_cyc(10);
    cmp_cnt++; if (n_valid - v0 !== 1) begin err_cnt++; $display("FAIL basic_valid_count got=%0d exp=1", n_valid - v0); end
    cmp_cnt++; if (got[v0 % 64] !== 8'hA5) begin err_cnt++; $display("FAIL basic_data got=%h exp=a5", got[v0 % 64]); end
    cmp_cnt++; if (n_ferr - f0 !== 0) begin err_cnt++; $display("FAIL basic_frame_err got=%0d exp=0", n_ferr - f0); end
    cmp_cnt++; if ((t_valid - t_fall < LAT - 1) || (t_valid - t_fall > LAT + 1)) begin
      err_cnt++; $display("FAIL basic_latency got=%0d exp=%0d+-1", t_valid - t_fall, LAT);
    end
    // busy spans START..STOP: from LAT-C/2-9C... i.e. edge 3 to edge LAT
    cmp_cnt++; if ((n_busy - b0 < LAT - 4) || (n_busy - b0 > LAT - 2)) begin
      err_cnt++; $display("FAIL basic_busy_cycles got=%0d exp=%0d+-1", n_busy - b0, LAT - 3);
    end
    cmp_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL basic_busy_after got=%b exp=0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = n_valid;
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    wait_cyc(10);
    cmp_cnt++; if (n_valid - v0 !== 2) begin err_cnt++; $display("FAIL b2b_valid_count got=%0d exp=2", n_valid - v0); end
    cmp_cnt++; if (got[v0 % 64] !== 8'h00) begin err_cnt++; $display("FAIL b2b_first got=%h exp=00", got[v0 % 64]); end
    cmp_cnt++; if (got[(v0 + 1) % 64] !== 8'hFF) begin err_cnt++; $display("FAIL b2b_second got=%h exp=ff", got[(v0 + 1) % 64]); end
  endtask

  task automatic test_glitch();
    int v0, f0, p0;
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    bus.rx = 1'b0;
    wait_cyc(6);
    bus.rx = 1'b1;
    wait_cyc(40);
    cmp_cnt++; if ((n_valid - v0) + (n_ferr - f0) + (n_perr - p0) !== 0) begin
      err_cnt++; $display("FAIL glitch_pulses got=%0d exp=0", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0));
    end
    cmp_cnt++; if (bus.rx_data !== 8'hFF) begin err_cnt++; $display("FAIL glitch_rx_data got=%h exp=ff", bus.rx_data); end
    cmp_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL glitch_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_frame_err();
    int v0, f0, b0;
    v0 = n_valid; f0 = n_ferr; b0 = n_busy;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_cyc(40);
    cmp_cnt++; if (n_ferr - f0 !== 1) begin err_cnt++; $display("FAIL ferr_count got=%0d exp=1", n_ferr - f0); end
    cmp_cnt++; if (n_valid - v0 !== 0) begin err_cnt++; $display("FAIL ferr_valid got=%0d exp=0", n_valid - v0); end
    cmp_cnt++; if (bus.rx_data !== 8'hFF) begin err_cnt++; $display("FAIL ferr_rx_data got=%h exp=ff", bus.rx_data); end
    // one frame's worth of busy only: held-low line must not retrigger
    cmp_cnt++; if (n_busy - b0 > LAT - 2) begin err_cnt++; $display("FAIL ferr_retrigger busy_cycles got=%0d max=%0d", n_busy - b0, LAT - 2); end
    cmp_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL ferr_busy got=%b exp=0", bus.busy); end
    bus.rx = 1'b1;
    wait_cyc(20);
    v0 = n_valid;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    wait_cyc(10);
    cmp_cnt++; if ((n_valid - v0 !== 1) || (got[v0 % 64] !== 8'h5A)) begin
      err_cnt++; $display("FAIL ferr_recover count=%0d data=%h exp=1/5a", n_valid - v0, got[v0 % 64]);
    end
  endtask

  task automatic test_reset_mid();
    int v0, f0, p0, b0;
    logic [7:0] d;
    d  = 8'h81;
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    bus.rx = d[4];
    wait_cyc(8);
    rst = 1'b1;
    wait_cyc(3);
    cmp_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL rstmid_busy_in_reset got=%b exp=0", bus.busy); end
    rst = 1'b0;
    b0 = n_busy;
    wait_cyc(C - 11);
    for (int i = 5; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);
    wait_cyc(20);
    cmp_cnt++; if ((n_valid - v0) + (n_ferr - f0) + (n_perr - p0) !== 0) begin
      err_cnt++; $display("FAIL rstmid_pulses got=%0d exp=0", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0));
    end
    cmp_cnt++; if (n_busy - b0 !== 0) begin err_cnt++; $display("FAIL rstmid_no_restart busy_cycles got=%0d exp=0", n_busy - b0); end
    cmp_cnt++; if (bus.rx_data !== 8'h00) begin err_cnt++; $display("FAIL rstmid_rx_data got=%h exp=00", bus.rx_data); end
    v0 = n_valid;
    send_frame(8'h42, 1'b1, 1'b0, 1'b0);
    wait_cyc(10);
    cmp_cnt++; if (n_valid - v0 !== 1) begin err_cnt++; $display("FAIL rstmid_valid_count got=%0d exp=1", n_valid - v0); end
    cmp_cnt++; if (got[v0 % 64] !== 8'h42) begin err_cnt++; $display("FAIL rstmid_data got=%h exp=42", got[v0 % 64]); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int v0, p0;
    v0 = n_valid; p0 = n_perr;
    // 0x07 has three ones, so the even-parity bit is 1
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    wait_cyc(10);
    cmp_cnt++; if (n_perr - p0 !== 1) begin err_cnt++; $display("FAIL par_bad_perr got=%0d exp=1", n_perr - p0); end
    cmp_cnt++; if (n_valid - v0 !== 0) begin err_cnt++; $display("FAIL par_bad_valid got=%0d exp=0", n_valid - v0); end
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    wait_cyc(10);
    cmp_cnt++; if (n_perr - p0 !== 0) begin err_cnt++; $display("FAIL par_good_perr got=%0d exp=0", n_perr - p0); end
    cmp_cnt++; if ((n_valid - v0 !== 1) || (got[v0 % 64] !== 8'h07)) begin
      err_cnt++; $display("FAIL par_good_valid count=%0d data=%h exp=1/07", n_valid - v0, got[v0 % 64]);
    end
    cmp_cnt++; if ((t_valid - t_fall < LAT + C - 1) || (t_valid - t_fall > LAT + C + 1)) begin
      err_cnt++; $display("FAIL par_latency got=%0d exp=%0d+-1", t_valid - t_fall, LAT + C);
    end
  endtask
`else
  task automatic test_no_parity();
    int p0;
    p0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    wait_cyc(10);
    cmp_cnt++; if ((n_perr - p0 !== 0) || (got[(n_valid - 1) % 64] !== 8'h07)) begin
      err_cnt++; $display("FAIL nopar_frame perr=%0d data=%h exp=0/07", n_perr - p0, got[(n_valid - 1) % 64]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`else
    test_no_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
